// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Generates the 640x480@60 Hz VGA raster from the 100 MHz system clock. A
// clock divider produces a pixel-rate advance. On each advance the column and
// line counters step. The sync pulses, the visible-area qualifier and the
// per-pixel / per-frame strobes are registered alongside the counters.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   asynchronous, active-high reset
//   hCount[9:0]  out  current pixel column, 0..H_TOTAL-1
//   vCount[9:0]  out  current line, 0..V_TOTAL-1
//   hSync        out  horizontal sync, active low (hCount < H_SYNC)
//   vSync        out  vertical sync, active low (vCount < V_SYNC)
//   bright       out  high inside the visible window (inclusive bounds)
//   pix_tick     out  one-clk pulse in the first clk cycle of each new pixel
//   frame_start  out  one-clk pulse in the first clk cycle of pixel (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV        = 4,    // system clocks per pixel, 1..16
    parameter int H_TOTAL        = 800,  // pixels per line, <= 1024
    parameter int H_SYNC         = 96,
    parameter int H_BRIGHT_START = 144,
    parameter int H_BRIGHT_END   = 783,
    parameter int V_TOTAL        = 525,  // lines per frame, <= 1024
    parameter int V_SYNC         = 2,
    parameter int V_BRIGHT_START = 35,
    parameter int V_BRIGHT_END   = 514
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_tick,
    output logic       frame_start
);

    // All counter comparisons are unsigned 10-bit. The constants are sized
    // once here so that every compare below is width-matched.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_BR_LO  = 10'(H_BRIGHT_START);
    localparam logic [9:0] H_BR_HI  = 10'(H_BRIGHT_END);
    localparam logic [9:0] V_BR_LO  = 10'(V_BRIGHT_START);
    localparam logic [9:0] V_BR_HI  = 10'(V_BRIGHT_END);

    logic [3:0] div;
    logic       advance;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_sync_next;
    logic       v_sync_next;
    logic       bright_next;

    // With CLK_DIV = 1 DIV_LAST is 0, so div stays at 0 and every edge
    // advances. pix_tick then stays high after the first edge.
    assign advance = (div == DIV_LAST);

    // Next raster position. The counters hold between advances, so the
    // decodes below are evaluated on the value the counters will hold.
    // Decoding the next value lets each registered output change on the same
    // edge as the counters.
    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (advance) begin
            if (hCount == H_LAST) begin
                h_next = '0;
                if (vCount == V_LAST) begin
                    v_next = '0;
                end else begin
                    v_next = vCount + 10'd1;
                end
            end else begin
                h_next = hCount + 10'd1;
            end
        end
    end

    always_comb begin
        h_sync_next = ~(h_next < H_SYNC_W);
        v_sync_next = ~(v_next < V_SYNC_W);
        bright_next = (h_next >= H_BR_LO) && (h_next <= H_BR_HI) &&
                      (v_next >= V_BR_LO) && (v_next <= V_BR_HI);
    end

    // Reset puts the raster at (0,0), which is inside both sync pulses. The
    // syncs are therefore low during reset, and no strobe is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= advance ? 4'd0 : div + 4'd1;
            hCount      <= h_next;
            vCount      <= v_next;
            hSync       <= h_sync_next;
            vSync       <= v_sync_next;
            bright      <= bright_next;
            pix_tick    <= advance;
            frame_start <= advance && (h_next == 10'd0) && (v_next == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Testbench for vga_timing_gen. It uses three instances:
//   u_dut   default 640x480 timing: reset mid-line, divider, hSync width,
//           line wrap.
//   u_small reduced raster (CLK_DIV=2, 20x12): a pixel scoreboard over two
//           frames and the frame_start period.
//   u_div1  reduced raster with CLK_DIV=1: one pixel per clk.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int S_DIV = 2;
    localparam int S_HT  = 20;
    localparam int S_HS  = 3;
    localparam int S_HB0 = 5;
    localparam int S_HB1 = 16;
    localparam int S_VT  = 12;
    localparam int S_VS  = 2;
    localparam int S_VB0 = 4;
    localparam int S_VB1 = 9;
    localparam int SB_N  = 500;   // pixels checked on u_small (> 2 frames)
    localparam int W     = 24;    // {h[9:0], v[9:0], hs, vs, br, fs}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    logic rst_1 = 1'b1;

    always #5 clk = ~clk;

    logic [9:0] d_h, d_v, s_h, s_v, o_h, o_v;
    logic d_hs, d_vs, d_br, d_pt, d_fs;
    logic s_hs, s_vs, s_br, s_pt, s_fs;
    logic o_hs, o_vs, o_br, o_pt, o_fs;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    bit frame_done = 0;
    bit div1_done  = 0;

    vga_timing_gen u_dut (
        .clk(clk), .rst(rst), .hCount(d_h), .vCount(d_v), .hSync(d_hs),
        .vSync(d_vs), .bright(d_br), .pix_tick(d_pt), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS),
        .H_BRIGHT_START(S_HB0), .H_BRIGHT_END(S_HB1),
        .V_TOTAL(S_VT), .V_SYNC(S_VS),
        .V_BRIGHT_START(S_VB0), .V_BRIGHT_END(S_VB1)
    ) u_small (
        .clk(clk), .rst(rst_s), .hCount(s_h), .vCount(s_v), .hSync(s_hs),
        .vSync(s_vs), .bright(s_br), .pix_tick(s_pt), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(S_HT), .H_SYNC(S_HS),
        .H_BRIGHT_START(S_HB0), .H_BRIGHT_END(S_HB1),
        .V_TOTAL(S_VT), .V_SYNC(S_VS),
        .V_BRIGHT_START(S_VB0), .V_BRIGHT_END(S_VB1)
    ) u_div1 (
        .clk(clk), .rst(rst_1), .hCount(o_h), .vCount(o_v), .hSync(o_hs),
        .vSync(o_vs), .bright(o_br), .pix_tick(o_pt), .frame_start(o_fs)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs of u_small after p advances since reset. The position
    // is computed directly from p, and the outputs from their definitions.
    function automatic logic [W-1:0] small_exp(input int p);
        int h, v;
        logic hs, vs, br, fs;
        h  = p % S_HT;
        v  = (p / S_HT) % S_VT;
        hs = !(h < S_HS);
        vs = !(v < S_VS);
        br = (h >= S_HB0) && (h <= S_HB1) && (v >= S_VB0) && (v <= S_VB1);
        fs = (h == 0) && (v == 0);
        return {10'(h), 10'(v), hs, vs, br, fs};
    endfunction

    // Wait for a pixel tick on u_dut showing column h; bounded by budget clks.
    task automatic wait_dut_h(input int h, input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (d_pt && int'(d_h) == h) ok = 1;
        end
        check(name, int'(ok), 1);
    endtask

    // ---------------- u_small: stimulus pushes expectations ----------------
    initial begin : small_stim
        repeat (3) @(negedge clk);
        check("small_rst_pix_tick", int'(s_pt), 0);
        check("small_rst_vsync", int'(s_vs), 0);
        for (int p = 1; p <= SB_N; p++) exp_q.push_back(small_exp(p));
        rst_s = 1'b0;
    end

    // ---------------- u_small: scoreboard monitor ----------------
    initial begin : sb_mon
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (s_pt && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_hcount", int'(s_h), int'(e[23:14]));
                check("sb_vcount", int'(s_v), int'(e[13:4]));
                check("sb_hsync",  int'(s_hs), int'(e[3]));
                check("sb_vsync",  int'(s_vs), int'(e[2]));
                check("sb_bright", int'(s_br), int'(e[1]));
                check("sb_frame_start", int'(s_fs), int'(e[0]));
            end
        end
    end

    // ---------------- u_small: frame_start period and width ----------------
    initial begin : frame_mon
        int t, last, seen;
        t = 0; last = -1; seen = 0;
        @(negedge rst_s);
        while (seen < 2 && t < 1500) begin
            @(negedge clk);
            t++;
            if (s_fs) begin
                if (last < 0) check("first_frame_start_clk", t, 480);
                else          check("frame_period_clks", t - last, 480);
                last = t;
                seen++;
                @(negedge clk);
                t++;
                check("frame_start_width", int'(s_fs), 0);
            end
        end
        check("frame_start_seen", seen, 2);
        frame_done = 1;
    end

    // ---------------- u_div1: one pixel per clk ----------------
    initial begin : div1_seq
        repeat (5) @(negedge clk);
        check("div1_rst_pix_tick", int'(o_pt), 0);
        rst_1 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            check("div1_hcount", int'(o_h), k % S_HT);
            check("div1_vcount", int'(o_v), k / S_HT);
            check("div1_pix_tick", int'(o_pt), 1);
        end
        div1_done = 1;
    end

    // ---------------- u_dut: default timing, then summary ----------------
    initial begin : main
        int ticks, last_tick, hs_low, v_before, waited;
        repeat (2) @(negedge clk);
        check("rst0_hcount", int'(d_h), 0);
        check("rst0_hsync", int'(d_hs), 0);
        check("rst0_vsync", int'(d_vs), 0);
        rst = 1'b0;

        // Assert reset mid-line at hCount = 400; everything clears at once.
        wait_dut_h(400, 2000, "reach_h400");
        #2 rst = 1'b1;
        #1;
        check("rst_mid_hcount", int'(d_h), 0);
        check("rst_mid_vcount", int'(d_v), 0);
        check("rst_mid_hsync", int'(d_hs), 0);
        check("rst_mid_vsync", int'(d_vs), 0);
        check("rst_mid_bright", int'(d_br), 0);
        check("rst_mid_pix_tick", int'(d_pt), 0);
        check("rst_mid_frame_start", int'(d_fs), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_hcount", int'(d_h), (k == 4) ? 1 : 0);
            check("post_rst_pix_tick", int'(d_pt), (k == 4) ? 1 : 0);
        end

        // 40 clks at CLK_DIV = 4: ten ticks, four clks apart.
        ticks = 0; last_tick = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_pt) begin
                if (last_tick >= 0) check("tick_spacing", i - last_tick, 4);
                last_tick = i;
                ticks++;
            end
        end
        check("ticks_in_40_clks", ticks, 10);

        // hSync low pixels over one full line (800 consecutive pixels).
        ticks = 0; hs_low = 0; waited = 0;
        while (ticks < 800 && waited < 3400) begin
            @(negedge clk);
            waited++;
            if (d_pt) begin
                ticks++;
                if (!d_hs) hs_low++;
            end
        end
        check("line_pixels_seen", ticks, 800);
        check("hsync_low_pixels", hs_low, 96);

        // Line wrap: 799 -> 0 with vCount + 1 on the same advance.
        wait_dut_h(799, 3400, "reach_h799");
        v_before = int'(d_v);
        wait_dut_h(0, 8, "wrap_to_h0");
        check("wrap_vcount", int'(d_v), v_before + 1);
        check("wrap_hsync", int'(d_hs), 0);
        check("wrap_bright", int'(d_br), 0);

        // Let the other processes finish, within a bound.
        waited = 0;
        while (!(frame_done && div1_done && exp_q.size() == 0) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check("frame_mon_done", int'(frame_done), 1);
        check("div1_done", int'(div1_done), 1);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing that the pixel renderers consume: free-running horizontal/vertical pixel counters, active-low sync pulses and the visible-area `bright` qualifier, all derived from the 100 MHz system clock through a pixel-rate clock enable. It sits between the board clock and every renderer and controller. Those blocks receive `hCount`, `vCount` and `bright` and return 12-bit RGB; the RGB path does not pass through this block.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; legal range 1..16.
- `H_TOTAL`, 800: pixels per line; must be ≤ 1024.
- `H_SYNC`, 96: hSync low width in pixels, at hCount 0..H_SYNC-1.
- `H_BRIGHT_START`, 144: first visible hCount.
- `H_BRIGHT_END`, 783: last visible hCount, inclusive.
- `V_TOTAL`, 525: lines per frame; must be ≤ 1024.
- `V_SYNC`, 2: vSync low width in lines, at vCount 0..V_SYNC-1.
- `V_BRIGHT_START`, 35: first visible line.
- `V_BRIGHT_END`, 514: last visible line, inclusive.

Ports (clock and reset first):
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `hCount`  out  10  current pixel column, 0..H_TOTAL-1.
- `vCount`  out  10  current line, 0..V_TOTAL-1.
- `hSync`  out  1  horizontal sync, active low.
- `vSync`  out  1  vertical sync, active low.
- `bright`  out  1  high when (hCount, vCount) is in the visible window.
- `pix_tick`  out  1  one-clk pulse in the first clk cycle of each new pixel.
- `frame_start`  out  1  one-clk pulse in the first clk cycle of pixel (0,0).

## Operation
- The divider counter `div` runs 0..CLK_DIV-1.
- An advance occurs on any clk edge where `div == CLK_DIV-1`. That edge sets `div` to 0 and steps the pixel counters.
- Pixel counter stepping:
  - `hCount == H_TOTAL-1`: hCount goes to 0 and vCount increments.
  - `vCount == V_TOTAL-1` at the same time: vCount goes to 0.
  - Otherwise hCount increments and vCount holds.
- On non-advance edges, `div` increments and the counters hold.
- All outputs are registered. Sync, bright, pix_tick and frame_start are computed from the next counter values, so they are cycle-aligned with `hCount`/`vCount` and have no decode glitches.
- `hSync = ~(hCount < H_SYNC)`.
- `vSync = ~(vCount < V_SYNC)`.
- `bright = (H_BRIGHT_START ≤ hCount ≤ H_BRIGHT_END) && (V_BRIGHT_START ≤ vCount ≤ V_BRIGHT_END)`, inclusive on both ends.
- `pix_tick` is 1 in the cycle after each advance, otherwise 0.
- `frame_start` is 1 in the cycle after an advance that lands on (0,0), otherwise 0.
- `CLK_DIV = 1`: every edge advances and `pix_tick` is held constantly 1 after the first edge.
- No enable or stall input; the raster runs free from reset release.
- Counter comparisons are unsigned 10-bit. Parameter relations are the integrator's responsibility and are not checked in RTL:
  - H_SYNC < H_BRIGHT_START ≤ H_BRIGHT_END < H_TOTAL
  - likewise for the vertical parameters.

## Timing
- Reset values while `rst` is high:
  - div = 0, hCount = 0, vCount = 0
  - hSync = 0, vSync = 0 (position (0,0) is inside both sync pulses)
  - bright = 0, pix_tick = 0, frame_start = 0
- First advance after reset release:
  - occurs on the CLK_DIV-th rising edge.
  - hCount becomes 1; `pix_tick` is 1 for that cycle.
  - `frame_start` stays 0 until the first wrap back to (0,0).
- Output latency: 0 clks relative to the counters. Every output reflects the current registered (hCount, vCount).
- Periods at defaults:
  - pixel: 4 clks
  - line: 800 pixels = 3200 clks
  - frame: 525 lines = 1,680,000 clks
- Pulse widths at defaults:
  - hSync low: 96 pixels = 384 clks per line.
  - vSync low: 2 lines = 1600 pixels.
- Reset asserted mid-frame: all state clears asynchronously within the same cycle, with no pulse emitted. The raster restarts from (0,0) with the first advance CLK_DIV edges after release.

## Test plan
- Reset: assert `rst` mid-line at hCount = 400 → same cycle: hCount = 0, vCount = 0, hSync = 0, vSync = 0, bright = 0, pix_tick = 0. After release, hCount = 1 on the 4th clk edge.
- Divider: run 40 clks at CLK_DIV = 4 → exactly 10 `pix_tick` pulses, spaced 4 clks apart. Rerun at CLK_DIV = 1 → hCount increments every clk.
- Horizontal sync and wrap: count `hSync` low pixels over one line → 96. hCount 799 → 0 with vCount +1 on the same edge.
- Bright edges: at vCount = 35, bright = 0 at hCount 143, 1 at 144, 1 at 783, 0 at 784. Bright = 0 for every hCount on vCount 34 and 515.
- Frame wrap: from (799, 524) the next advance gives (0,0), `frame_start` = 1 for exactly 1 clk, vSync = 0 for lines 0–1 and 1 from line 2. Measure 1,680,000 clks between consecutive `frame_start` pulses.
